// File: rtl/tx_status_pkg.sv
// Shared encodings and register-map constants for the transmission status tracker.
package tx_status_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StRunning = ST_RUNNING,
        StDone    = ST_DONE
    } tx_state_e;

    localparam int unsigned NUM_REGS = 7;
    localparam int unsigned REG_W    = 32;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_LOOP     = 1;
    localparam int unsigned REG_WORDS_LO = 2;
    localparam int unsigned REG_WORDS_HI = 3;
    localparam int unsigned REG_OVF      = 4;
    localparam int unsigned REG_ACTIVE   = 5;
    localparam int unsigned REG_BUILD    = 6;

    localparam int unsigned BIT_LIMIT    = 0;
    localparam int unsigned BIT_ACTIVE   = 1;
    localparam int unsigned BIT_OVF      = 2;
    localparam int unsigned BIT_STATE_LO = 3;

    function automatic logic [REG_W-1:0] pack_ctrl(input logic limit, input logic ovf,
                                                   input tx_state_e st);
        logic [REG_W-1:0] w;
        w                    = '0;
        w[BIT_LIMIT]         = limit;
        w[BIT_ACTIVE]        = (st == StRunning);
        w[BIT_OVF]           = ovf;
        w[BIT_STATE_LO +: 2] = st;
        return w;
    endfunction

endpackage

// File: rtl/transmission_status_tracker_if.sv
// Control/stream inputs and packed status outputs of the transmission status tracker.
interface transmission_status_tracker_if;
    import tx_status_pkg::*;

    logic                         enable;
    logic [31:0]                  loop_limit;
    logic                         frame_done;
    logic                         tvalid;
    logic                         tready;
    logic                         overflow;
    logic                         clear_counters;
    logic [NUM_REGS*REG_W-1:0]    status_regs_pl;
    logic                         transmission_active;

    modport master (
        output enable, loop_limit, frame_done, tvalid, tready, overflow, clear_counters,
        input  status_regs_pl, transmission_active
    );

    modport slave (
        input  enable, loop_limit, frame_done, tvalid, tready, overflow, clear_counters,
        output status_regs_pl, transmission_active
    );

endinterface

// File: rtl/transmission_status_tracker_sat_counter.sv
// Counter with synchronous clear (dominates increment) and optional saturation at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(SATURATE && (&count_q))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/transmission_status_tracker.sv
// Run-control FSM plus lifecycle counters, published as a registered 7x32-bit status bus.
module transmission_status_tracker
    import tx_status_pkg::*;
#(
    parameter logic [31:0] BUILD_ID = 32'h0000_0001
) (
    input  logic                          clk,
    input  logic                          rstn,
    transmission_status_tracker_if.slave  tx_if
);

    tx_state_e state_d, state_q;
    logic      start_run, running, limit_hit;
    logic      limit_d, limit_q;
    logic      ovf_sticky_d, ovf_sticky_q;

    logic [31:0] loop_count, ovf_count, active_cycles;
    logic [63:0] words_sent;

    logic [NUM_REGS*REG_W-1:0] status_d, status_q;

    assign running = (state_q == StRunning);

    // Limit compare uses the live loop_limit; a lowered limit only matches again after wrap.
    assign limit_hit = running && tx_if.frame_done && (tx_if.loop_limit != 32'd0) &&
                       ((loop_count + 32'd1) == tx_if.loop_limit);

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_if.enable) begin
                    state_d   = StRunning;
                    start_run = 1'b1;
                end
            end
            StRunning: begin
                if (limit_hit) begin
                    state_d = StDone;
                end else if (!tx_if.enable) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (!tx_if.enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        limit_d = limit_q;
        if (start_run) begin
            limit_d = 1'b0;
        end else if (limit_hit) begin
            limit_d = 1'b1;
        end

        ovf_sticky_d = ovf_sticky_q;
        if (tx_if.clear_counters) begin
            ovf_sticky_d = 1'b0;
        end else if (tx_if.overflow) begin
            ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            limit_q      <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    sat_counter #(.WIDTH(32), .SATURATE(1'b0)) u_loop (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (running && tx_if.frame_done),
        .clr     (tx_if.clear_counters || start_run),
        .count_o (loop_count)
    );

    sat_counter #(.WIDTH(64), .SATURATE(1'b0)) u_words (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (running && tx_if.tvalid && tx_if.tready),
        .clr     (tx_if.clear_counters || start_run),
        .count_o (words_sent)
    );

    sat_counter #(.WIDTH(32), .SATURATE(1'b1)) u_ovf (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (tx_if.overflow),
        .clr     (tx_if.clear_counters),
        .count_o (ovf_count)
    );

    sat_counter #(.WIDTH(32), .SATURATE(1'b1)) u_active (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (running),
        .clr     (tx_if.clear_counters || start_run),
        .count_o (active_cycles)
    );

    always_comb begin
        status_d                                = '0;
        status_d[REG_CTRL*REG_W     +: REG_W]   = pack_ctrl(limit_q, ovf_sticky_q, state_q);
        status_d[REG_LOOP*REG_W     +: REG_W]   = loop_count;
        status_d[REG_WORDS_LO*REG_W +: REG_W]   = words_sent[31:0];
        status_d[REG_WORDS_HI*REG_W +: REG_W]   = words_sent[63:32];
        status_d[REG_OVF*REG_W      +: REG_W]   = ovf_count;
        status_d[REG_ACTIVE*REG_W   +: REG_W]   = active_cycles;
        status_d[REG_BUILD*REG_W    +: REG_W]   = BUILD_ID;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            status_q                             <= '0;
            status_q[REG_BUILD*REG_W +: REG_W]   <= BUILD_ID;
        end else begin
            status_q <= status_d;
        end
    end

    assign tx_if.status_regs_pl      = status_q;
    assign tx_if.transmission_active = status_q[REG_CTRL*REG_W + BIT_ACTIVE];

endmodule

// File: tb/tb_transmission_status_tracker.sv
// Directed bench for transmission_status_tracker with hand-computed expected register values.
module tb_transmission_status_tracker;

    localparam logic [31:0] BUILD = 32'h1234_5678;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fails;

    transmission_status_tracker_if tif ();

    transmission_status_tracker #(.BUILD_ID(BUILD)) u_dut (
        .clk   (clk),
        .rstn  (rstn),
        .tx_if (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get_reg(input int n);
        return tif.status_regs_pl[n*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        tif.frame_done = 1'b1;
        step();
        tif.frame_done = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rstn               = 1'b0;
        tif.enable         = 1'b0;
        tif.loop_limit     = 32'd0;
        tif.frame_done     = 1'b0;
        tif.tvalid         = 1'b0;
        tif.tready         = 1'b0;
        tif.overflow       = 1'b0;
        tif.clear_counters = 1'b0;
        repeat (3) step();

        // Reset state
        for (int r = 0; r < 6; r++) check_eq($sformatf("reset_reg%0d", r), 64'(get_reg(r)), 64'd0);
        check_eq("reset_build", 64'(get_reg(6)), 64'(BUILD));
        check_eq("reset_active_o", 64'(tif.transmission_active), 64'd0);
        rstn = 1'b1;
        step();

        // Limited run of 3 frames
        tif.loop_limit = 32'd3;
        tif.enable     = 1'b1;
        step();
        step();
        check_eq("run_reg0", 64'(get_reg(0)), 64'h0A);
        check_eq("run_active_o", 64'(tif.transmission_active), 64'd1);
        repeat (3) frame_pulse();
        step();
        check_eq("limit_reg1", 64'(get_reg(1)), 64'd3);
        check_eq("limit_reg0", 64'(get_reg(0)), 64'h11);
        check_eq("limit_reg5", 64'(get_reg(5)), 64'd4);
        tif.enable = 1'b0;
        step();
        step();
        check_eq("done_idle_reg0", 64'(get_reg(0)), 64'h01);
        frame_pulse();
        step();
        check_eq("idle_frame_ignored", 64'(get_reg(1)), 64'd3);
        tif.enable = 1'b1;
        step();
        step();
        check_eq("rerun_reg0", 64'(get_reg(0)), 64'h0A);
        check_eq("rerun_reg1", 64'(get_reg(1)), 64'd0);

        // Unlimited run, then abort
        tif.loop_limit = 32'd0;
        for (int i = 0; i < 1000; i++) begin
            frame_pulse();
            step();
        end
        step();
        check_eq("unlim_reg1", 64'(get_reg(1)), 64'd1000);
        check_eq("unlim_reg0", 64'(get_reg(0)), 64'h0A);
        tif.enable = 1'b0;
        step();
        step();
        check_eq("abort_reg0", 64'(get_reg(0)), 64'h00);
        check_eq("abort_reg1", 64'(get_reg(1)), 64'd1000);

        // Overflow in IDLE, then clear coincident with a third pulse
        repeat (2) begin
            tif.overflow = 1'b1;
            step();
            tif.overflow = 1'b0;
            step();
        end
        check_eq("ovf_reg4", 64'(get_reg(4)), 64'd2);
        check_eq("ovf_reg0", 64'(get_reg(0)), 64'h04);
        tif.overflow       = 1'b1;
        tif.clear_counters = 1'b1;
        step();
        tif.overflow       = 1'b0;
        tif.clear_counters = 1'b0;
        step();
        check_eq("clr_reg4", 64'(get_reg(4)), 64'd0);
        check_eq("clr_reg0", 64'(get_reg(0)), 64'h00);
        check_eq("clr_reg1", 64'(get_reg(1)), 64'd0);

        // Word counting: no handshake without tready, then 32-bit carry
        tif.enable = 1'b1;
        step();
        tif.tvalid = 1'b1;
        step();
        step();
        tif.tvalid = 1'b0;
        step();
        check_eq("noready_reg2", 64'(get_reg(2)), 64'd0);
        force u_dut.u_words.count_q = 64'h0000_0000_FFFF_FFFF;
        step();
        release u_dut.u_words.count_q;
        check_eq("preload_reg2", 64'(get_reg(2)), 64'hFFFF_FFFF);
        check_eq("preload_reg3", 64'(get_reg(3)), 64'd0);
        tif.tvalid = 1'b1;
        tif.tready = 1'b1;
        step();
        tif.tvalid = 1'b0;
        tif.tready = 1'b0;
        step();
        check_eq("carry_reg2", 64'(get_reg(2)), 64'd0);
        check_eq("carry_reg3", 64'(get_reg(3)), 64'd1);

        // Final frame coincides with enable falling: limit wins
        tif.enable = 1'b0;
        step();
        step();
        tif.loop_limit = 32'd2;
        tif.enable     = 1'b1;
        step();
        frame_pulse();
        tif.frame_done = 1'b1;
        tif.enable     = 1'b0;
        step();
        tif.frame_done = 1'b0;
        step();
        check_eq("race_done_reg0", 64'(get_reg(0)), 64'h11);
        check_eq("race_reg1", 64'(get_reg(1)), 64'd2);
        step();
        check_eq("race_idle_reg0", 64'(get_reg(0)), 64'h01);

        // Reset in the middle of a run
        tif.loop_limit = 32'd0;
        tif.enable     = 1'b1;
        step();
        tif.frame_done = 1'b1;
        tif.tvalid     = 1'b1;
        tif.tready     = 1'b1;
        tif.overflow   = 1'b1;
        step();
        tif.frame_done = 1'b0;
        tif.tvalid     = 1'b0;
        tif.tready     = 1'b0;
        tif.overflow   = 1'b0;
        step();
        check_eq("pre_rst_reg0", 64'(get_reg(0)), 64'h0E);
        check_eq("pre_rst_reg1", 64'(get_reg(1)), 64'd1);
        check_eq("pre_rst_reg2", 64'(get_reg(2)), 64'd1);
        check_eq("pre_rst_reg4", 64'(get_reg(4)), 64'd1);
        rstn = 1'b0;
        step();
        for (int r = 0; r < 6; r++) check_eq($sformatf("midrst_reg%0d", r), 64'(get_reg(r)), 64'd0);
        check_eq("midrst_build", 64'(get_reg(6)), 64'(BUILD));
        check_eq("midrst_active_o", 64'(tif.transmission_active), 64'd0);
        rstn = 1'b1;
        step();
        step();
        check_eq("fresh_reg0", 64'(get_reg(0)), 64'h0A);
        check_eq("fresh_reg1", 64'(get_reg(1)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
